// File: rtl/handle_table.sv
// Handle table: ENTRIES handle-to-base mappings with registered address translation
// and a command port (ALLOC by next-fit scan, FREE, SET_BASE).
module handle_table #(
  parameter  int W         = 16,
  parameter  int ID_BITS   = 7,
  parameter  int ENTRIES   = 16,
  localparam int OFF_BITS  = W - 1 - ID_BITS,
  localparam int BASE_BITS = W - OFF_BITS
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_req_valid,
  input  logic [W-1:0]         i_address,
  output logic                 o_valid,
  output logic [W-1:0]         o_address,
  output logic                 o_fault,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic [1:0]           i_cmd_op,
  input  logic [ID_BITS-1:0]   i_cmd_id,
  input  logic [BASE_BITS-1:0] i_cmd_base,
  output logic                 o_cmd_done,
  output logic [ID_BITS-1:0]   o_cmd_id,
  output logic                 o_cmd_err
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int CNT_W = $clog2(ENTRIES + 1);
  localparam logic [ID_BITS:0] ENTRIES_ID = (ID_BITS + 1)'(ENTRIES);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(ENTRIES - 1);
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(ENTRIES - 1);

  typedef enum logic [1:0] {
    OP_ALLOC    = 2'd0,
    OP_FREE     = 2'd1,
    OP_SET_BASE = 2'd2,
    OP_RSVD     = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Table and command-engine state
  logic [ENTRIES-1:0]   valid_q, valid_d;
  logic [BASE_BITS-1:0] base_q [ENTRIES];
  logic [BASE_BITS-1:0] base_d [ENTRIES];
  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     scan_idx_q, scan_idx_d;
  logic [CNT_W-1:0]     scan_cnt_q, scan_cnt_d;
  logic [BASE_BITS-1:0] cmd_base_q, cmd_base_d;

  // Registered outputs
  logic                 valid_out_q, valid_out_d;
  logic [W-1:0]         addr_q, addr_d;
  logic                 fault_q, fault_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 cmd_done_q, cmd_done_d;
  logic [ID_BITS-1:0]   cmd_id_q, cmd_id_d;
  logic                 cmd_err_q, cmd_err_d;

  // Translation lookup
  logic [ID_BITS-1:0]   tr_id;
  logic [IDX_W-1:0]     tr_idx;
  logic                 tr_hit;

  // Command target lookup
  logic [IDX_W-1:0]     cmd_idx;
  logic                 cmd_hit;
  logic [IDX_W-1:0]     scan_next;

  assign tr_id     = i_address[W-2:OFF_BITS];
  assign tr_idx    = tr_id[IDX_W-1:0];
  assign tr_hit    = ({1'b0, tr_id} < ENTRIES_ID) && valid_q[tr_idx];
  assign cmd_idx   = i_cmd_id[IDX_W-1:0];
  assign cmd_hit   = ({1'b0, i_cmd_id} < ENTRIES_ID) && valid_q[cmd_idx];
  assign scan_next = (scan_idx_q == LAST_IDX) ? '0 : scan_idx_q + 1'b1;

  // Translation reads valid_q/base_q, so a same-cycle command update is seen
  // only by the following request.
  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise a path
    // that skips an assignment infers a latch.
    valid_out_d = i_req_valid;
    addr_d      = addr_q;
    fault_d     = fault_q;
    if (i_req_valid) begin
      if (!i_address[W-1]) begin
        addr_d  = i_address;
        fault_d = 1'b0;
      end else if (tr_hit) begin
        addr_d  = {base_q[tr_idx], i_address[OFF_BITS-1:0]};
        fault_d = 1'b0;
      end else begin
        addr_d  = '0;
        fault_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    scan_idx_d = scan_idx_q;
    scan_cnt_d = scan_cnt_q;
    cmd_base_d = cmd_base_q;
    valid_d    = valid_q;
    base_d     = base_q;
    cmd_id_d   = cmd_id_q;
    cmd_err_d  = cmd_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_cmd_valid) begin
          cmd_base_d = i_cmd_base;
          unique case (op_e'(i_cmd_op))
            OP_ALLOC: begin
              scan_idx_d = ptr_q;
              scan_cnt_d = '0;
              state_d    = S_SCAN;
            end
            OP_FREE: begin
              cmd_id_d  = i_cmd_id;
              cmd_err_d = !cmd_hit;
              if (cmd_hit) valid_d[cmd_idx] = 1'b0;
              state_d   = S_DONE;
            end
            OP_SET_BASE: begin
              cmd_id_d  = i_cmd_id;
              cmd_err_d = !cmd_hit;
              if (cmd_hit) base_d[cmd_idx] = i_cmd_base;
              state_d   = S_DONE;
            end
            OP_RSVD: begin
              cmd_id_d  = i_cmd_id;
              cmd_err_d = 1'b1;
              state_d   = S_DONE;
            end
          endcase
        end
      end
      S_SCAN: begin
        if (!valid_q[scan_idx_q]) begin
          valid_d[scan_idx_q] = 1'b1;
          base_d[scan_idx_q]  = cmd_base_q;
          cmd_id_d            = ID_BITS'(scan_idx_q);
          cmd_err_d           = 1'b0;
          ptr_d               = scan_next;
          state_d             = S_DONE;
        end else if (scan_cnt_q == LAST_CNT) begin
          // Every entry examined once: table full, pointer left alone.
          cmd_id_d  = '0;
          cmd_err_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          scan_idx_d = scan_next;
          scan_cnt_d = scan_cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    cmd_done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      // NOTE: the base array is reset because its contents are architecturally
      // visible (reset state is all bases zero); plain data RAMs need not be.
      valid_q     <= '0;
      base_q      <= '{default: '0};
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      scan_idx_q  <= '0;
      scan_cnt_q  <= '0;
      cmd_base_q  <= '0;
      valid_out_q <= 1'b0;
      addr_q      <= '0;
      fault_q     <= 1'b0;
      cmd_ready_q <= 1'b1;
      cmd_done_q  <= 1'b0;
      cmd_id_q    <= '0;
      cmd_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // value of its _d regardless of statement order.
      valid_q     <= valid_d;
      base_q      <= base_d;
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      scan_idx_q  <= scan_idx_d;
      scan_cnt_q  <= scan_cnt_d;
      cmd_base_q  <= cmd_base_d;
      valid_out_q <= valid_out_d;
      addr_q      <= addr_d;
      fault_q     <= fault_d;
      cmd_ready_q <= cmd_ready_d;
      cmd_done_q  <= cmd_done_d;
      cmd_id_q    <= cmd_id_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  assign o_valid     = valid_out_q;
  assign o_address   = addr_q;
  assign o_fault     = fault_q;
  assign o_cmd_ready = cmd_ready_q;
  assign o_cmd_done  = cmd_done_q;
  assign o_cmd_id    = cmd_id_q;
  assign o_cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_handle_table.sv
// Directed bench for handle_table: translation vector table plus hand-written
// command sequences (fill, full scan, wrap, same-cycle update, mid-scan reset).
module tb_handle_table;

  localparam int W         = 16;
  localparam int ID_BITS   = 7;
  localparam int ENTRIES   = 16;
  localparam int BASE_BITS = 8;

  logic                 clk = 1'b0;
  logic                 i_reset;
  logic                 i_req_valid;
  logic [W-1:0]         i_address;
  logic                 o_valid;
  logic [W-1:0]         o_address;
  logic                 o_fault;
  logic                 i_cmd_valid;
  logic                 o_cmd_ready;
  logic [1:0]           i_cmd_op;
  logic [ID_BITS-1:0]   i_cmd_id;
  logic [BASE_BITS-1:0] i_cmd_base;
  logic                 o_cmd_done;
  logic [ID_BITS-1:0]   o_cmd_id;
  logic                 o_cmd_err;

  always #5 clk = ~clk;

  handle_table #(.W(W), .ID_BITS(ID_BITS), .ENTRIES(ENTRIES)) dut (
    .i_clock     (clk),
    .i_reset     (i_reset),
    .i_req_valid (i_req_valid),
    .i_address   (i_address),
    .o_valid     (o_valid),
    .o_address   (o_address),
    .o_fault     (o_fault),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_op    (i_cmd_op),
    .i_cmd_id    (i_cmd_id),
    .i_cmd_base  (i_cmd_base),
    .o_cmd_done  (o_cmd_done),
    .o_cmd_id    (o_cmd_id),
    .o_cmd_err   (o_cmd_err)
  );

  typedef struct {
    logic [W-1:0] addr;
    logic [W-1:0] exp_addr;
    logic         exp_fault;
  } xlat_t;

  xlat_t vec [15];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Back-to-back translation requests, each result checked one cycle later,
  // then one idle cycle to confirm the outputs hold.
  task automatic run_vectors(input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      i_req_valid = 1'b1;
      i_address   = vec[i].addr;
      tick();
      check($sformatf("xlat[%0d] valid", i), o_valid, 1);
      check($sformatf("xlat[%0d] addr", i), o_address, vec[i].exp_addr);
      check($sformatf("xlat[%0d] fault", i), o_fault, vec[i].exp_fault);
    end
    i_req_valid = 1'b0;
    i_address   = 16'hdead;
    tick();
    check("idle valid", o_valid, 0);
    check("idle addr hold", o_address, vec[first + count - 1].exp_addr);
    check("idle fault hold", o_fault, vec[first + count - 1].exp_fault);
  endtask

  // Issue one command, then scramble the command inputs to prove they are latched.
  // exp_n = cycles from accept to the done pulse (k+1 for ALLOC, 0 otherwise).
  task automatic do_cmd(input string name, input logic [1:0] op, input logic [6:0] id,
                        input logic [7:0] base, input int exp_n,
                        input logic [6:0] exp_id, input logic exp_err);
    int n;
    bit ready_low;
    check({name, " ready before"}, o_cmd_ready, 1);
    i_cmd_valid = 1'b1;
    i_cmd_op    = op;
    i_cmd_id    = id;
    i_cmd_base  = base;
    tick();
    i_cmd_valid = 1'b0;
    i_cmd_op    = ~op;
    i_cmd_id    = ~id;
    i_cmd_base  = ~base;
    n         = 0;
    ready_low = 1'b1;
    while (!o_cmd_done && n < 40) begin
      if (o_cmd_ready) ready_low = 1'b0;
      tick();
      n++;
    end
    check({name, " latency"}, n, exp_n);
    check({name, " ready low while busy"}, {31'd0, ready_low && !o_cmd_ready}, 1);
    check({name, " id"}, o_cmd_id, exp_id);
    check({name, " err"}, o_cmd_err, exp_err);
    tick();
    check({name, " done one cycle"}, o_cmd_done, 0);
    check({name, " ready after"}, o_cmd_ready, 1);
  endtask

  initial begin
    bit saw_done;

    vec[0]  = '{16'h0123, 16'h0123, 1'b0};
    vec[1]  = '{16'h8066, 16'h0000, 1'b1};
    vec[2]  = '{16'h8066, 16'h0566, 1'b0};
    vec[3]  = '{16'h812c, 16'h072c, 1'b0};
    vec[4]  = '{16'h7fff, 16'h7fff, 1'b0};
    vec[5]  = '{16'h8266, 16'h0000, 1'b1};
    vec[6]  = '{16'hff00, 16'h0000, 1'b1};
    vec[7]  = '{16'h9000, 16'h0000, 1'b1};
    vec[8]  = '{16'h8f01, 16'h1f01, 1'b0};
    vec[9]  = '{16'h8201, 16'h1201, 1'b0};
    vec[10] = '{16'h8355, 16'h0955, 1'b0};
    vec[11] = '{16'h8101, 16'h0000, 1'b1};
    vec[12] = '{16'h8066, 16'h0000, 1'b1};
    vec[13] = '{16'h8f01, 16'h0000, 1'b1};
    vec[14] = '{16'h8012, 16'h4412, 1'b0};

    i_reset     = 1'b1;
    i_req_valid = 1'b0;
    i_address   = '0;
    i_cmd_valid = 1'b0;
    i_cmd_op    = '0;
    i_cmd_id    = '0;
    i_cmd_base  = '0;
    tick();
    tick();
    check("rst o_valid", o_valid, 0);
    check("rst o_address", o_address, 0);
    check("rst o_fault", o_fault, 0);
    check("rst o_cmd_ready", o_cmd_ready, 1);
    check("rst o_cmd_done", o_cmd_done, 0);
    check("rst o_cmd_id", o_cmd_id, 0);
    check("rst o_cmd_err", o_cmd_err, 0);
    i_reset = 1'b0;

    run_vectors(0, 2);

    do_cmd("alloc b5", 2'd0, 7'd0, 8'h05, 1, 7'd0, 1'b0);
    do_cmd("alloc b7", 2'd0, 7'd0, 8'h07, 1, 7'd1, 1'b0);
    run_vectors(2, 6);

    for (int i = 2; i < ENTRIES; i++)
      do_cmd($sformatf("fill %0d", i), 2'd0, 7'd0, 8'(8'h10 + i), 1, 7'(i), 1'b0);
    run_vectors(8, 2);

    do_cmd("alloc full", 2'd0, 7'd0, 8'h99, ENTRIES, 7'd0, 1'b1);
    do_cmd("free 3", 2'd1, 7'd3, 8'h00, 0, 7'd3, 1'b0);
    do_cmd("alloc b9", 2'd0, 7'd0, 8'h09, 4, 7'd3, 1'b0);
    run_vectors(10, 1);

    do_cmd("free 1", 2'd1, 7'd1, 8'h00, 0, 7'd1, 1'b0);
    run_vectors(11, 1);
    do_cmd("free 1 again", 2'd1, 7'd1, 8'h00, 0, 7'd1, 1'b1);
    do_cmd("set_base 20", 2'd2, 7'd20, 8'h11, 0, 7'd20, 1'b1);
    do_cmd("op3", 2'd3, 7'd0, 8'h00, 0, 7'd0, 1'b1);

    // SET_BASE with a same-cycle translate: old base first, new base next.
    check("setb ready", o_cmd_ready, 1);
    i_cmd_valid = 1'b1;
    i_cmd_op    = 2'd2;
    i_cmd_id    = 7'd0;
    i_cmd_base  = 8'h0a;
    i_req_valid = 1'b1;
    i_address   = 16'h8011;
    tick();
    i_cmd_valid = 1'b0;
    check("setb same-cycle addr", o_address, 16'h0511);
    check("setb same-cycle fault", o_fault, 0);
    check("setb done", o_cmd_done, 1);
    check("setb err", o_cmd_err, 0);
    tick();
    i_req_valid = 1'b0;
    check("setb next addr", o_address, 16'h0a11);
    check("setb next valid", o_valid, 1);
    tick();

    // Pointer at 4, only entry 1 free: scan 4..15, 0, 1 wraps around.
    do_cmd("alloc wrap", 2'd0, 7'd0, 8'h21, 14, 7'd1, 1'b0);

    // Reset during a full-table scan.
    check("midrst ready", o_cmd_ready, 1);
    i_cmd_valid = 1'b1;
    i_cmd_op    = 2'd0;
    i_cmd_base  = 8'h33;
    tick();
    i_cmd_valid = 1'b0;
    tick();
    tick();
    check("midrst scanning", o_cmd_ready, 0);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check("midrst ready after", o_cmd_ready, 1);
    check("midrst done after", o_cmd_done, 0);
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (o_cmd_done) saw_done = 1'b1;
      tick();
    end
    check("midrst no done pulse", {31'd0, saw_done}, 0);
    run_vectors(12, 2);
    do_cmd("alloc after rst", 2'd0, 7'd0, 8'h44, 1, 7'd0, 1'b0);
    run_vectors(14, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
